// File: rtl/core_seq.sv
// core_seq: shader core executing one 16-bit opcode at a time into a 2*BIT_WIDTH accumulator.
// Multiplies run as a BIT_WIDTH-cycle shift-add on operands captured at accept.
module core_seq #(
    parameter int unsigned CORE_ID       = 0,
    parameter int unsigned BIT_WIDTH     = 8,
    parameter int unsigned NR_LOCAL_REGS = 8,
    parameter bit          SATURATE      = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    input  logic [15:0]              opcode,
    output logic                     op_ready,
    input  logic [16*BIT_WIDTH-1:0]  global_registers_in,
    output logic [2*BIT_WIDTH-1:0]   accu,
    output logic                     done,
    output logic                     acc_zero,
    output logic                     acc_neg
);
    localparam int unsigned BW    = BIT_WIDTH;
    localparam int unsigned AW    = 2 * BIT_WIDTH;
    localparam int unsigned CNT_W = $clog2(BIT_WIDTH);
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {IDLE, MUL} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            r_ready;
    logic                            r_done;
    logic [AW-1:0]                   r_accu;
    logic [NR_LOCAL_REGS-1:0][BW-1:0] r_local;
    logic [CNT_W-1:0]                r_cnt;
    logic [AW-1:0]                   r_mcand;
    logic [BW-1:0]                   r_mplier;
    logic [AW-1:0]                   r_prod;
    logic                            r_mac;
    logic                            r_sub;

    logic                            w_accept;
    logic [1:0]                      w_cls;
    logic [4:0]                      w_src_a;
    logic [4:0]                      w_src_b;
    logic [4:0]                      w_dest;
    logic [BW-1:0]                   w_op_a;
    logic [BW-1:0]                   w_op_b;
    logic [BW-1:0]                   w_imm;
    logic [AW-1:0]                   w_alu_a;
    logic [AW-1:0]                   w_alu_b;
    logic [AW:0]                     w_sum;
    logic [AW:0]                     w_neg;
    logic [3:0]                      w_shamt;
    logic [AW-1:0]                   w_shl;
    logic [AW-1:0]                   w_shr;
    logic [AW-1:0]                   w_product;
    logic [AW-1:0]                   w_mac_res;
    logic [AW-1:0]                   w_mul_wb;
    logic [AW-1:0]                   w_accu_nxt;
    logic                            w_ready_nxt;
    logic                            w_done_nxt;
    logic                            w_local_we;
    logic [BW-1:0]                   w_local_wdata;
    logic                            w_mul_start;

    // Register-file read: locals, zeros, CORE_ID at 15, globals at 16..31.
    function automatic logic [BW-1:0] read_reg(
        input logic [4:0]                       idx,
        input logic [NR_LOCAL_REGS-1:0][BW-1:0] locals,
        input logic [16*BW-1:0]                 globals
    );
        logic [BW-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NR_LOCAL_REGS; i++)
            if (idx == 5'(i)) v = locals[i];
        if (idx == 5'd15) v = BW'(CORE_ID);
        for (int unsigned i = 0; i < 16; i++)
            if (idx == 5'(16 + i)) v = globals[BW*i +: BW];
        return v;
    endfunction

    // Signed overflow of a one-bit-extended result shows as differing top two bits.
    function automatic logic [AW-1:0] clamp(input logic [AW:0] v);
        if (SATURATE && (v[AW] != v[AW-1])) return v[AW] ? ACC_MIN : ACC_MAX;
        return v[AW-1:0];
    endfunction

    assign w_accept = op_valid & r_ready;
    assign w_cls    = opcode[15:14];
    assign w_src_a  = opcode[13:9];
    assign w_src_b  = {1'b0, opcode[8:5]};
    assign w_dest   = opcode[13:9];
    assign w_op_a   = read_reg(w_src_a, r_local, global_registers_in);
    assign w_op_b   = read_reg(w_src_b, r_local, global_registers_in);
    assign w_imm    = BW'($signed(opcode[7:0]));

    assign w_alu_a  = opcode[2] ? r_accu : {{(AW-BW){w_op_a[BW-1]}}, w_op_a};
    assign w_alu_b  = opcode[3] ? r_accu : {{(AW-BW){w_op_b[BW-1]}}, w_op_b};
    assign w_sum    = opcode[0] ? ({w_alu_a[AW-1], w_alu_a} - {w_alu_b[AW-1], w_alu_b})
                                : ({w_alu_a[AW-1], w_alu_a} + {w_alu_b[AW-1], w_alu_b});
    assign w_neg    = {(AW+1){1'b0}} - {r_accu[AW-1], r_accu};
    assign w_shamt  = opcode[7:4];
    assign w_shl    = (32'(w_shamt) >= AW) ? '0 : (r_accu << w_shamt);
    assign w_shr    = (32'(w_shamt) >= AW) ? {AW{r_accu[AW-1]}}
                                           : AW'($signed(r_accu) >>> w_shamt);

    // Last partial product folds in combinationally on the final MUL edge.
    assign w_product = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_mac_res = r_sub ? (r_accu - w_product) : (r_accu + w_product);
    assign w_mul_wb  = r_mac ? w_mac_res : w_product;

    always_comb begin
        w_state_nxt   = r_state;
        w_accu_nxt    = r_accu;
        w_ready_nxt   = r_ready;
        w_done_nxt    = 1'b0;
        w_local_we    = 1'b0;
        w_local_wdata = '0;
        w_mul_start   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_done_nxt = 1'b1;
                    case (w_cls)
                        2'b00: begin
                            w_local_we    = 1'b1;
                            w_local_wdata = w_imm;
                        end
                        2'b01: begin
                            if (opcode[1]) begin
                                w_mul_start = 1'b1;
                                w_state_nxt = MUL;
                                w_ready_nxt = 1'b0;
                                w_done_nxt  = 1'b0;
                            end else begin
                                w_accu_nxt = clamp(w_sum);
                            end
                        end
                        2'b10: begin
                            case (opcode[1:0])
                                2'b00:   w_accu_nxt = '0;
                                2'b01:   w_accu_nxt = clamp(w_neg);
                                2'b10:   w_accu_nxt = w_shl;
                                default: w_accu_nxt = w_shr;
                            endcase
                        end
                        default: begin
                            w_local_we    = opcode[8];
                            w_local_wdata = r_accu[BW-1:0];
                        end
                    endcase
                end
            end
            MUL: begin
                if (r_cnt == CNT_W'(BW - 1)) begin
                    w_state_nxt = IDLE;
                    w_accu_nxt  = w_mul_wb;
                    w_ready_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Datapath and handshake registers; reset also aborts an in-flight multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_accu   <= '0;
            r_local  <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_mac    <= 1'b0;
            r_sub    <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            r_accu  <= w_accu_nxt;
            for (int unsigned i = 0; i < NR_LOCAL_REGS; i++)
                if (w_local_we && (w_dest == 5'(i))) r_local[i] <= w_local_wdata;
            if (w_mul_start) begin
                r_mcand  <= {{(AW-BW){1'b0}}, w_op_a};
                r_mplier <= w_op_b;
                r_prod   <= '0;
                r_cnt    <= '0;
                r_mac    <= opcode[4];
                r_sub    <= opcode[0];
            end else if (r_state == MUL) begin
                r_prod   <= w_product;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign op_ready = r_ready;
    assign accu     = r_accu;
    assign done     = r_done;
    assign acc_zero = (r_accu == '0);
    assign acc_neg  = r_accu[AW-1];
endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: drives a wrapping and a saturating core_seq with the same opcode stream
// and compares both against an integer-arithmetic reference model.
module tb_core_seq;
    logic         clk;
    logic         reset;
    logic         op_valid;
    logic [15:0]  opcode;
    logic [127:0] glob;
    logic         ready_o [2];
    logic [15:0]  accu_o  [2];
    logic         done_o  [2];
    logic         zero_o  [2];
    logic         neg_o   [2];

    int n_checks;
    int n_errors;
    int m_accu [2];
    int m_loc  [2][8];

    core_seq #(.CORE_ID(2), .BIT_WIDTH(8), .NR_LOCAL_REGS(8), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode), .op_ready(ready_o[0]),
        .global_registers_in(glob), .accu(accu_o[0]), .done(done_o[0]),
        .acc_zero(zero_o[0]), .acc_neg(neg_o[0]));

    core_seq #(.CORE_ID(2), .BIT_WIDTH(8), .NR_LOCAL_REGS(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .op_valid(op_valid), .opcode(opcode), .op_ready(ready_o[1]),
        .global_registers_in(glob), .accu(accu_o[1]), .done(done_o[1]),
        .acc_zero(zero_o[1]), .acc_neg(neg_o[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its end in time");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic int sx8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int s16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic int fit(input int v, input bit sat);
        int r;
        r = v;
        if (sat && r > 32767)  r = 32767;
        if (sat && r < -32768) r = -32768;
        return r & 'hFFFF;
    endfunction

    function automatic int mrd(input int k, input int idx);
        if (idx < 8)   return m_loc[k][idx];
        if (idx == 15) return 2;
        if (idx >= 16) return int'(glob[(idx-16)*8 +: 8]);
        return 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_accu[k] = 0;
            for (int r = 0; r < 8; r++) m_loc[k][r] = 0;
        end
    endtask

    task automatic model_apply(input logic [15:0] op);
        int a, b, x, y, p, n;
        a = int'(op[13:9]);
        b = int'(op[8:5]);
        n = int'(op[7:4]);
        for (int k = 0; k < 2; k++) begin
            case (op[15:14])
                2'b00: if (a < 8) m_loc[k][a] = int'(op[7:0]);
                2'b01: begin
                    if (op[1]) begin
                        p = mrd(k, a) * mrd(k, b);
                        if (op[4]) m_accu[k] = (op[0] ? m_accu[k] - p : m_accu[k] + p) & 'hFFFF;
                        else       m_accu[k] = p;
                    end else begin
                        x = op[2] ? s16(m_accu[k]) : sx8(mrd(k, a));
                        y = op[3] ? s16(m_accu[k]) : sx8(mrd(k, b));
                        m_accu[k] = fit(op[0] ? x - y : x + y, k == 1);
                    end
                end
                2'b10: begin
                    case (op[1:0])
                        2'b00:   m_accu[k] = 0;
                        2'b01:   m_accu[k] = fit(-s16(m_accu[k]), k == 1);
                        2'b10:   m_accu[k] = (m_accu[k] << n) & 'hFFFF;
                        default: m_accu[k] = (s16(m_accu[k]) >>> n) & 'hFFFF;
                    endcase
                end
                default: if (op[8] && a < 8) m_loc[k][a] = m_accu[k] & 'hFF;
            endcase
        end
    endtask

    // ---------------- opcode builders and sampling ----------------
    function automatic logic [15:0] op_load(input logic [4:0] d, input logic [7:0] imm);
        return {2'b00, d, 1'b0, imm};
    endfunction
    function automatic logic [15:0] op_alu(input logic [4:0] a, input logic [3:0] b, input logic [4:0] low);
        return {2'b01, a, b, low};
    endfunction
    function automatic logic [15:0] op_sh(input logic [1:0] sel, input logic [3:0] amt);
        return {2'b10, 5'd0, 1'b0, amt, 2'b00, sel};
    endfunction
    function automatic logic [15:0] op_store(input logic [4:0] d);
        return {2'b11, d, 1'b1, 8'h00};
    endfunction

    function automatic logic [19:0] obs(input int k);
        return {ready_o[k], done_o[k], zero_o[k], neg_o[k], accu_o[k]};
    endfunction
    function automatic logic [19:0] expv(input bit rdy, input bit dn, input int a);
        logic [15:0] v;
        v = 16'(a);
        return {rdy, dn, v == 16'h0000, v[15], v};
    endfunction

    // Issue one opcode at a negedge and follow it to retirement; ends on a negedge.
    task automatic exec_op(input logic [15:0] op, input bit chg_glob = 1'b0,
                           input bit hold = 1'b0, input logic [15:0] hold_op = 16'h0);
        bit          is_mul;
        int          prev [2];
        logic [19:0] e;
        is_mul   = (op[15:14] == 2'b01) && op[1];
        prev     = m_accu;
        op_valid = 1'b1;
        opcode   = op;
        model_apply(op);
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        if (is_mul) begin
            if (chg_glob) glob = {$urandom, $urandom, $urandom, $urandom};
            if (hold) begin
                op_valid = 1'b1;
                opcode   = hold_op;
            end
            for (int c = 0; c < 8; c++) begin
                if (c > 0) @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    e = expv(1'b0, 1'b0, prev[k]);
                    n_checks++;
                    if (obs(k) !== e) begin
                        n_errors++;
                        $display("FAIL mul_busy[%0d] cyc %0d op %h: got rdy/done/z/n/accu=%h expected %h",
                                 k, c + 1, op, obs(k), e);
                    end
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            e = expv(1'b1, 1'b1, m_accu[k]);
            n_checks++;
            if (obs(k) !== e) begin
                n_errors++;
                $display("FAIL retire[%0d] op %h: got rdy/done/z/n/accu=%h expected %h", k, op, obs(k), e);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [19:0] e;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = expv(1'b1, 1'b0, 0);
            n_checks++;
            if (obs(k) !== e) begin
                n_errors++;
                $display("FAIL reset_state[%0d]: got %h expected %h", k, obs(k), e);
            end
        end
        reset = 1'b0;
        model_reset();
        for (int r = 0; r < 8; r++) exec_op(op_alu(5'(r), 4'd14, 5'b00000));
    endtask

    task automatic test_mul();
        exec_op(op_load(5'd1, 8'h05));
        exec_op(op_load(5'd2, 8'h03));
        exec_op(op_alu(5'd1, 4'd2, 5'b00010));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== 16'h000F) begin
                n_errors++;
                $display("FAIL mul_5x3[%0d]: got %h expected 000f", k, accu_o[k]);
            end
        end
    endtask

    task automatic test_mac_shadow();
        exec_op(op_load(5'd1, 8'hFF));
        exec_op(op_load(5'd2, 8'hFF));
        exec_op(op_alu(5'd1, 4'd2, 5'b10010));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== 16'hFE10) begin
                n_errors++;
                $display("FAIL mac_add[%0d]: got %h expected fe10", k, accu_o[k]);
            end
        end
        glob[15:8] = 8'h11;
        exec_op(op_alu(5'd17, 4'd1, 5'b00010), 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== 16'h10EF) begin
                n_errors++;
                $display("FAIL mul_shadow[%0d]: got %h expected 10ef", k, accu_o[k]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] exp_c [2];
        exec_op(op_load(5'd1, 8'h40));
        exec_op(op_alu(5'd1, 4'd14, 5'b00000));
        exec_op(op_sh(2'b10, 4'd8));
        exec_op(op_alu(5'd0, 4'd0, 5'b01100));
        exp_c[0] = 16'h8000;
        exp_c[1] = 16'h7FFF;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== exp_c[k]) begin
                n_errors++;
                $display("FAIL sat_add[%0d]: got %h expected %h", k, accu_o[k], exp_c[k]);
            end
        end
        exec_op(op_sh(2'b00, 4'd0));
        exec_op(op_load(5'd1, 8'h80));
        exec_op(op_alu(5'd1, 4'd14, 5'b00000));
        exec_op(op_sh(2'b10, 4'd8));
        exec_op(op_sh(2'b01, 4'd0));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== exp_c[k]) begin
                n_errors++;
                $display("FAIL sat_neg[%0d]: got %h expected %h", k, accu_o[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_store();
        exec_op(op_sh(2'b00, 4'd0));
        exec_op(op_load(5'd1, 8'h12));
        exec_op(op_alu(5'd1, 4'd14, 5'b00000));
        exec_op(op_sh(2'b10, 4'd8));
        exec_op(op_load(5'd2, 8'h55));
        exec_op(op_alu(5'd0, 4'd2, 5'b00100));
        exec_op(op_load(5'd3, 8'h56));
        exec_op(op_alu(5'd0, 4'd3, 5'b00100));
        exec_op(op_store(5'd3));
        exec_op(op_alu(5'd3, 4'd15, 5'b00000));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== 16'hFFAD) begin
                n_errors++;
                $display("FAIL store_core_id[%0d]: got %h expected ffad", k, accu_o[k]);
            end
        end
        exec_op(op_store(5'd12));
        exec_op(op_alu(5'd14, 4'd12, 5'b00000));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== 16'h0000) begin
                n_errors++;
                $display("FAIL store_dropped[%0d]: got %h expected 0000", k, accu_o[k]);
            end
        end
    endtask

    task automatic test_hold_during_mul();
        logic [15:0] held;
        held = op_load(5'd4, 8'h7E);
        exec_op(op_alu(5'd1, 4'd2, 5'b00011), 1'b0, 1'b1, held);
        exec_op(held);
        exec_op(op_alu(5'd4, 4'd14, 5'b00000));
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (accu_o[k] !== 16'h007E) begin
                n_errors++;
                $display("FAIL held_load[%0d]: got %h expected 007e", k, accu_o[k]);
            end
        end
    endtask

    task automatic test_reset_in_mul();
        logic [19:0] e;
        exec_op(op_load(5'd1, 8'h07));
        exec_op(op_load(5'd2, 8'h09));
        exec_op(op_alu(5'd1, 4'd14, 5'b00000));
        op_valid = 1'b1;
        opcode   = op_alu(5'd1, 4'd2, 5'b00010);
        @(posedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                e = expv(1'b0, 1'b0, 7);
                n_checks++;
                if (obs(k) !== e) begin
                    n_errors++;
                    $display("FAIL abort_busy[%0d] cyc %0d: got %h expected %h", k, c, obs(k), e);
                end
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            e = expv(1'b1, 1'b0, 0);
            n_checks++;
            if (obs(k) !== e) begin
                n_errors++;
                $display("FAIL abort_reset[%0d]: got %h expected %h", k, obs(k), e);
            end
        end
        exec_op(op_load(5'd5, 8'h33));
        exec_op(op_alu(5'd5, 4'd1, 5'b00000));
    endtask

    task automatic test_back_to_back();
        logic [15:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 16'($urandom);
            if (op[15:14] == 2'b01) op[1] = 1'b0;
            exec_op(op);
        end
    endtask

    task automatic test_random();
        logic [15:0] op;
        logic [19:0] e;
        for (int n = 0; n < 200; n++) begin
            op = 16'($urandom);
            if ($urandom_range(0, 3) == 0) glob = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    e = expv(1'b1, 1'b0, m_accu[k]);
                    n_checks++;
                    if (obs(k) !== e) begin
                        n_errors++;
                        $display("FAIL idle[%0d]: got %h expected %h", k, obs(k), e);
                    end
                end
            end
            exec_op(op, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        op_valid = 1'b0;
        opcode   = 16'h0000;
        glob     = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        test_reset();
        test_mul();
        test_mac_shadow();
        test_saturate();
        test_store();
        test_hold_during_mul();
        test_reset_in_mul();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
